// File: rtl/stall_mgmt_ctrl.sv
// rtl/stall_mgmt_ctrl.sv - global stall/flush/drain sequencer for the buffered pipeline
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   buf_full       per-stage buffer full status  [NUM_STAGES]
//   buf_empty      per-stage buffer empty status [NUM_STAGES]
//   ext_stall      downstream backpressure request
//   flush_req      flush request level, sampled every cycle
//   stall          global stall, decoded from registered state
//   flush          global flush, decoded from registered state
//   src_hold       stop the source from presenting new data (combinational)
//   ctrl_state     current state: RUN=0 STALL=1 DRAIN=2 FLUSH=3
//   stall_cycles   cycles spent with stall high (saturating)
//   drain_cycles   cycles spent in DRAIN (saturating)
//
// Optional feature macro: STALL_PERF_CNT_EN enables the two performance
// counters; without it both counter outputs are constant 0.
module stall_mgmt_ctrl #(
    parameter int NUM_STAGES   = 4,
    parameter int MIN_STALL    = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] buf_full,
    input  logic [NUM_STAGES-1:0] buf_empty,
    input  logic                  ext_stall,
    input  logic                  flush_req,
    output logic                  stall,
    output logic                  flush,
    output logic                  src_hold,
    output logic [1:0]            ctrl_state,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           drain_cycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LOAD  = 8'(MIN_STALL - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic [3:0] flush_cnt, flush_cnt_nxt;
    logic       all_empty;
    logic       any_full;

    assign all_empty = &buf_empty;
    assign any_full  = |buf_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            hold_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        hold_cnt_nxt  = hold_cnt;
        flush_cnt_nxt = flush_cnt;
        if (flush_req) begin
            // A flush request overrides every state, including an ongoing flush.
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
        end else begin
            case (state)
                ST_RUN: begin
                    // buf_full in RUN is a protocol error and deliberately ignored.
                    if (ext_stall) begin
                        state_nxt    = ST_STALL;
                        hold_cnt_nxt = HOLD_LOAD;
                    end
                end
                ST_STALL: begin
                    if (hold_cnt != 8'd0) begin
                        hold_cnt_nxt = hold_cnt - 8'd1;
                    end else if (!ext_stall) begin
                        state_nxt = all_empty ? ST_RUN : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Re-stall has priority over finishing the drain.
                    if (ext_stall) begin
                        state_nxt    = ST_STALL;
                        hold_cnt_nxt = HOLD_LOAD;
                    end else if (all_empty) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    // Buffers are cleared by the flush, so no DRAIN afterwards.
                    if (flush_cnt != 4'd0) begin
                        flush_cnt_nxt = flush_cnt - 4'd1;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    assign stall      = (state == ST_STALL);
    assign flush      = (state == ST_FLUSH);
    assign ctrl_state = state;
    // The buf_full term is combinational so a full buffer blocks the source
    // in the same cycle and no input is dropped.
    assign src_hold   = (stall && any_full) || (state == ST_DRAIN) || flush;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] drain_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((state == ST_DRAIN) && (drain_cnt_q != 32'hFFFF_FFFF)) begin
                drain_cnt_q <= drain_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign drain_cycles = drain_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign drain_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_stall_mgmt_ctrl.sv
// tb/tb_stall_mgmt_ctrl.sv - self-checking bench for stall_mgmt_ctrl
module tb_stall_mgmt_ctrl;

    localparam int NS = 4;
    localparam int MS = 2;
    localparam int FC = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NS-1:0] buf_full = '0;
    logic [NS-1:0] buf_empty = '1;
    logic          ext_stall = 1'b0;
    logic          flush_req = 1'b0;
    logic          stall;
    logic          flush;
    logic          src_hold;
    logic [1:0]    ctrl_state;
    logic [31:0]   stall_cycles;
    logic [31:0]   drain_cycles;

    int total = 0;
    int bad = 0;

    // Reference model: mode plus "how long have we been here" ages.
    int     m_state;
    int     m_age;
    int     m_fage;
    longint m_sc;
    longint m_dc;

    always #5 clk = ~clk;

    stall_mgmt_ctrl #(
        .NUM_STAGES  (NS),
        .MIN_STALL   (MS),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .buf_full    (buf_full),
        .buf_empty   (buf_empty),
        .ext_stall   (ext_stall),
        .flush_req   (flush_req),
        .stall       (stall),
        .flush       (flush),
        .src_hold    (src_hold),
        .ctrl_state  (ctrl_state),
        .stall_cycles(stall_cycles),
        .drain_cycles(drain_cycles)
    );

    function automatic logic m_hold_exp();
        return (m_state == 1 && (buf_full != '0)) || m_state == 2 || m_state == 3;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_age   = 0;
        m_fage  = 0;
        m_sc    = 0;
        m_dc    = 0;
    endtask

    // Advance one clock: predict from current inputs, then commit after the edge.
    task automatic tick();
        int     n;
        int     age;
        int     fage;
        longint sc;
        longint dc;
        bit     all_empty;
        all_empty = (buf_empty == {NS{1'b1}});
        n    = m_state;
        age  = m_age;
        fage = m_fage;
        sc   = (m_state == 1 && m_sc < 64'hFFFF_FFFF) ? m_sc + 1 : m_sc;
        dc   = (m_state == 2 && m_dc < 64'hFFFF_FFFF) ? m_dc + 1 : m_dc;
        if (flush_req) begin
            n = 3; fage = 0;
        end else if (m_state == 0) begin
            if (ext_stall) begin n = 1; age = 0; end
        end else if (m_state == 1) begin
            age = m_age + 1;   // cycles stall has been visible, this one included
            if (age >= MS && !ext_stall) n = all_empty ? 0 : 2;
        end else if (m_state == 2) begin
            if (ext_stall) begin n = 1; age = 0; end
            else if (all_empty) n = 0;
        end else begin
            fage = m_fage + 1;
            if (fage >= FC) n = 0;
        end
        @(posedge clk);
        m_state = n; m_age = age; m_fage = fage; m_sc = sc; m_dc = dc;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        buf_full = '0; buf_empty = '0; ext_stall = 1'b0; flush_req = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
        total++; if (src_hold !== 1'b0) begin bad++; $display("FAIL reset_src_hold got=%b exp=0", src_hold); end
        total++; if (ctrl_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", ctrl_state); end
        total++; if (stall_cycles !== 32'd0 || drain_cycles !== 32'd0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, drain_cycles);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({stall, flush, src_hold, ctrl_state} !== 5'b0) begin
                bad++; $display("FAIL idle_%0d got=%b exp=00000", i, {stall, flush, src_hold, ctrl_state});
            end
        end
        // Asynchronous reset in the middle of a stall.
        buf_empty = '1; ext_stall = 1'b1; buf_full = 4'b0001;
        tick();
        total++; if (ctrl_state !== 2'd1) begin bad++; $display("FAIL pre_async_state got=%0d exp=1", ctrl_state); end
        #2 reset = 1'b1;
        #1;
        model_reset();
        total++; if ({stall, src_hold, ctrl_state} !== 4'b0) begin
            bad++; $display("FAIL async_reset got=%b exp=0000", {stall, src_hold, ctrl_state});
        end
        @(negedge clk);
        reset = 1'b0; ext_stall = 1'b0; buf_full = '0;
    endtask

    task automatic test_short_stall();
        buf_empty = '1;
        ext_stall = 1'b1;
        tick();
        ext_stall = 1'b0;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL short_stall_c1 got=%b exp=1", stall); end
        tick();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL short_stall_c2 got=%b exp=1", stall); end
        tick();
        total++; if (ctrl_state !== 2'd0 || stall !== 1'b0) begin
            bad++; $display("FAIL short_stall_exit got=%0d/%b exp=0/0", ctrl_state, stall);
        end
    endtask

    task automatic test_fill_drain();
        buf_empty = '1;
        ext_stall = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            if (i == 3) begin
                #1;
                total++; if (src_hold !== 1'b0) begin bad++; $display("FAIL fill_pre_hold got=%b exp=0", src_hold); end
                buf_full  = 4'b0010;
                buf_empty = 4'b1101;
                #1;
                total++; if (src_hold !== 1'b1) begin bad++; $display("FAIL fill_same_cycle_hold got=%b exp=1", src_hold); end
            end
            tick();
        end
        ext_stall = 1'b0;
        buf_full  = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (ctrl_state !== 2'd2 || stall !== 1'b0 || src_hold !== 1'b1) begin
                bad++; $display("FAIL drain_%0d got=%0d/%b/%b exp=2/0/1", i, ctrl_state, stall, src_hold);
            end
        end
        buf_empty = '1;
        tick();
        total++; if (ctrl_state !== 2'd0) begin bad++; $display("FAIL drain_exit got=%0d exp=0", ctrl_state); end
    endtask

    task automatic test_flush_preempt();
        buf_empty = '1;
        ext_stall = 1'b1;
        tick();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL preflush_stall got=%b exp=1", stall); end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        total++; if (flush !== 1'b1 || stall !== 1'b0 || ctrl_state !== 2'd3) begin
            bad++; $display("FAIL flush_pulse got=%b/%b/%0d exp=1/0/3", flush, stall, ctrl_state);
        end
        tick();
        total++; if (ctrl_state !== 2'd0 || flush !== 1'b0) begin
            bad++; $display("FAIL flush_exit got=%0d/%b exp=0/0", ctrl_state, flush);
        end
        tick();
        total++; if (ctrl_state !== 2'd1) begin bad++; $display("FAIL flush_restall got=%0d exp=1", ctrl_state); end
        ext_stall = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_restall_drain();
        int stall_run;
        buf_empty = 4'h0;
        ext_stall = 1'b1;
        tick();
        ext_stall = 1'b0;
        tick();
        tick();
        total++; if (ctrl_state !== 2'd2) begin bad++; $display("FAIL restall_in_drain got=%0d exp=2", ctrl_state); end
        ext_stall = 1'b1;
        tick();
        ext_stall = 1'b0;
        total++; if (ctrl_state !== 2'd1) begin bad++; $display("FAIL restall_entry got=%0d exp=1", ctrl_state); end
        stall_run = 0;
        for (int i = 0; i < 8 && stall === 1'b1; i++) begin
            stall_run++;
            tick();
        end
        total++; if (stall_run < MS) begin bad++; $display("FAIL restall_min got=%0d exp>=%0d", stall_run, MS); end
        total++; if (ctrl_state !== 2'd2) begin bad++; $display("FAIL restall_back_drain got=%0d exp=2", ctrl_state); end
        buf_empty = '1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            ext_stall = ($urandom_range(0, 99) < 35);
            flush_req = ($urandom_range(0, 99) < 4);
            buf_empty = ($urandom_range(0, 1) == 1) ? {NS{1'b1}} : NS'($urandom);
            buf_full  = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
            #1;
            total++; if (src_hold !== m_hold_exp()) begin
                bad++; $display("FAIL rand_src_hold i=%0d got=%b exp=%b", i, src_hold, m_hold_exp());
            end
            tick();
            total++; if (ctrl_state !== 2'(m_state)) begin
                bad++; $display("FAIL rand_state i=%0d got=%0d exp=%0d", i, ctrl_state, m_state);
            end
            total++; if (stall !== (m_state == 1) || flush !== (m_state == 3)) begin
                bad++; $display("FAIL rand_stall_flush i=%0d got=%b/%b exp=%b/%b", i, stall, flush, m_state == 1, m_state == 3);
            end
`ifdef STALL_PERF_CNT_EN
            total++; if (stall_cycles !== 32'(m_sc) || drain_cycles !== 32'(m_dc)) begin
                bad++; $display("FAIL rand_counters i=%0d got=%0d/%0d exp=%0d/%0d", i, stall_cycles, drain_cycles, m_sc, m_dc);
            end
`else
            total++; if (stall_cycles !== 32'd0 || drain_cycles !== 32'd0) begin
                bad++; $display("FAIL rand_counters_off i=%0d got=%0d/%0d exp=0/0", i, stall_cycles, drain_cycles);
            end
`endif
        end
        ext_stall = 1'b0; flush_req = 1'b0; buf_full = '0; buf_empty = '1;
        repeat (4) tick();
    endtask

    task automatic test_perf();
        buf_full = '0; buf_empty = 4'h0; ext_stall = 1'b0; flush_req = 1'b0;
        do_reset();
        ext_stall = 1'b1;
        repeat (7) tick();
        ext_stall = 1'b0;
        tick();
        total++; if (ctrl_state !== 2'd2) begin bad++; $display("FAIL perf_drain_entry got=%0d exp=2", ctrl_state); end
        tick();
        tick();
        buf_empty = '1;
        tick();
        total++; if (ctrl_state !== 2'd0) begin bad++; $display("FAIL perf_run got=%0d exp=0", ctrl_state); end
`ifdef STALL_PERF_CNT_EN
        total++; if (stall_cycles !== 32'd7) begin bad++; $display("FAIL perf_stall_cycles got=%0d exp=7", stall_cycles); end
        total++; if (drain_cycles !== 32'd3) begin bad++; $display("FAIL perf_drain_cycles got=%0d exp=3", drain_cycles); end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        total++; if (stall_cycles !== 32'd7 || drain_cycles !== 32'd3) begin
            bad++; $display("FAIL perf_after_flush got=%0d/%0d exp=7/3", stall_cycles, drain_cycles);
        end
`else
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL perf_off_stall got=%0d exp=0", stall_cycles); end
        total++; if (drain_cycles !== 32'd0) begin bad++; $display("FAIL perf_off_drain got=%0d exp=0", drain_cycles); end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        repeat (2) tick();
        test_short_stall();
        test_fill_drain();
        test_flush_preempt();
        test_restall_drain();
        test_random();
        test_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stall_mgmt_ctrl.md
Name: stall_mgmt_ctrl

Overview:
Central global-stall controller for the buffered pipeline. It collects per-stage buffer full/empty status, downstream backpressure and flush requests, and produces the global stall, flush pulse and source hold signals. It sequences drain-down after a stall so that buffered slots empty before the source resumes.

Parameters:
NUM_STAGES, 4, number of buffer stages monitored (1..16)
MIN_STALL, 2, minimum cycles stall stays asserted once entered (1..255)
FLUSH_CYCLES, 1, cycles flush is held high per flush request (1..15)

Ports:
clk  in  1  clock
reset  in  1  async reset, active-high
buf_full  in  NUM_STAGES  per-stage buffer full (to_stall_mgmt)
buf_empty  in  NUM_STAGES  per-stage buffer empty
ext_stall  in  1  downstream backpressure request
flush_req  in  1  flush request (level; sampled each cycle)
stall  out  1  global stall to all buffers, registered
flush  out  1  global flush to all buffers, registered
src_hold  out  1  stop the source from asserting in_valid (combinational, see below)
ctrl_state  out  2  current FSM state encoding
stall_cycles  out  32  performance counter (optional feature)
drain_cycles  out  32  performance counter (optional feature)

Behaviour:
- Reset is asynchronous, active-high, with clock clk. On reset: state RUN; stall=0, flush=0, src_hold=0; all counters 0. Reset mid-operation aborts any stall/drain/flush immediately.
- States and encoding: RUN=0, STALL=1, DRAIN=2, FLUSH=3. stall, flush and ctrl_state are decoded from registered state: stall=1 only in STALL, flush=1 only in FLUSH. Latency from an input to stall/flush is 1 cycle.
- src_hold = (STALL & |buf_full) | DRAIN | FLUSH. The buf_full term is combinational so no input is dropped at a full buffer.
- Priority in every state: flush_req wins. It moves to FLUSH and loads flush_cnt=FLUSH_CYCLES-1.
- RUN: ext_stall=1 -> STALL, and hold_cnt loads MIN_STALL-1.
- STALL: hold_cnt decrements to 0, then holds.
  - Exit only when hold_cnt==0 and ext_stall=0.
  - On exit: if &buf_empty -> RUN, else -> DRAIN.
- DRAIN: stall=0, so buffers shift out one entry per cycle.
  - &buf_empty -> RUN.
  - ext_stall=1 (and &buf_empty=0) -> STALL with hold_cnt reload.
  - If &buf_empty and ext_stall are both 1 -> STALL.
- FLUSH: flush_cnt decrements.
  - At 0 -> RUN. If flush_req is still high, re-enter FLUSH with a reload.
  - ext_stall is ignored in FLUSH.
  - Flush clears the buffers, so no DRAIN follows.
- A buf_full bit seen while in RUN is a protocol error (a buffer fills only under stall). It is ignored for state transitions.
- buf_empty/buf_full bits above NUM_STAGES do not exist; the reductions cover exactly NUM_STAGES bits.

Optional Feature:
STALL_PERF_CNT_EN. When defined:
- stall_cycles increments each cycle stall=1.
- drain_cycles increments each cycle state==DRAIN.
- Both are 32-bit, saturate at 0xFFFFFFFF, are cleared by reset, and are not cleared by flush.

When undefined, both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset then idle: reset 3 cycles, release, all inputs 0 -> stall=0, flush=0, src_hold=0, ctrl_state=0 for 10 cycles.
- Short stall: ext_stall=1 for 1 cycle at cycle 5 with MIN_STALL=2 and all buf_empty=1. Required: stall high at cycles 6-7, and back to RUN at cycle 8 because the buffers are empty.
- Stall with fill and drain: ext_stall high for 10 cycles and buf_full[1]=1 from cycle 9. Required:
  - src_hold=1 in the same cycle buf_full[1] rises.
  - After ext_stall drops, state=DRAIN and stall=0 until buf_empty=4'hF, then RUN.
- Flush preempts stall: in STALL, pulse flush_req at cycle 20 with FLUSH_CYCLES=1. Required: flush=1 at cycle 21, stall=0, then RUN at cycle 22 even with ext_stall=1 held. At cycle 22 ext_stall is reconsidered, giving STALL at cycle 23.
- Re-stall during drain: in DRAIN with buf_empty=4'h0, assert ext_stall. Required: STALL next cycle with stall held ≥MIN_STALL cycles.
- Perf counters (STALL_PERF_CNT_EN): 7 stall cycles plus 3 drain cycles give stall_cycles=7 and drain_cycles=3. Without the macro, both read 0.
